// File: rtl/bcd_clock_pkg.sv
// Shared constants and helpers for the 24-hour BCD clock: digit validation
// and the 24h-to-12h display mapping.
package bcd_clock_pkg;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;

  // Both nibbles must be decimal digits; with that, BCD compares like binary.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // Returns {pm, hh} with hh in 01..12 for a 24-hour BCD hour 00..23.
  function automatic logic [8:0] h24_to_h12(input logic [7:0] h24);
    logic [4:0] bin_s;
    logic [4:0] b12_s;
    logic [7:0] hh_s;
    bin_s = 5'(h24[5:4]) * 5'd10 + 5'(h24[3:0]);
    b12_s = bin_s - 5'd12;
    if (bin_s == 5'd0) begin
      hh_s = BCD_12;
    end else if (bin_s <= 5'd12) begin
      hh_s = h24;
    end else if (b12_s >= 5'd10) begin
      hh_s = {4'h1, 4'(b12_s - 5'd10)};
    end else begin
      hh_s = {4'h0, b12_s[3:0]};
    end
    return {(h24 >= BCD_12), hh_s};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX -> 00; carry_out flags an increment
// that wraps, so instances chain seconds -> minutes -> hours.
module bcd_mod_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic [7:0] q_next,
  output logic       carry_out
);

  logic [7:0] q_r;

  // Value the counter takes on its next increment.
  always_comb begin
    q_next = 8'h00;
    if (q_r == MAX) begin
      q_next = 8'h00;
    end else if (q_r[3:0] == 4'h9) begin
      q_next = {q_r[7:4] + 4'h1, 4'h0};
    end else begin
      q_next = {q_r[7:4], q_r[3:0] + 4'h1};
    end
  end

  assign carry_out = inc && (q_r == MAX);
  assign q         = q_r;

  // Count register: load has priority over increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r <= 8'h00;
    end else if (load) begin
      q_r <= load_val;
    end else if (inc) begin
      q_r <= q_next;
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/bcd_clock_24h_alarm.sv
// 24-hour BCD clock with prescaler, validated time load, daily hh:mm alarm
// and 12h/24h display selection.
module bcd_clock_24h_alarm
  import bcd_clock_pkg::*;
#(
  parameter int DIV = 1,
  parameter int PW  = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic       mode24,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       alarm_hit,
  output logic       load_err
);

  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  logic [PW-1:0] pcnt_r;
  logic          advance_s, load_ok_s, load_acc_s, alarm_match_s;
  logic [7:0]    s_q_s, m_q_s, h_q_s;
  logic [7:0]    s_nxt_s, m_nxt_s, h_nxt_s;
  logic [7:0]    m_new_s, h_new_s;
  logic          s_carry_s, m_carry_s, h_carry_s;
  logic [8:0]    h12_s;
  logic          sec_tick_r, day_wrap_r, alarm_hit_r, load_err_r;

  assign load_ok_s  = bcd_valid(load_hh, BCD_23) && bcd_valid(load_mm, BCD_59)
                   && bcd_valid(load_ss, BCD_59);
  assign load_acc_s = load && load_ok_s;
  // Any load request, even a rejected one, suppresses the prescaler.
  assign advance_s  = ena && !load && (pcnt_r == DIV_M1);

  // Prescaler: counts ena cycles, cleared by an accepted load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_r <= '0;
    end else if (load_acc_s) begin
      pcnt_r <= '0;
    end else if (load) begin
      pcnt_r <= pcnt_r;
    end else if (ena) begin
      if (pcnt_r == DIV_M1) begin
        pcnt_r <= '0;
      end else begin
        pcnt_r <= pcnt_r + PW'(1);
      end
    end else begin
      pcnt_r <= pcnt_r;
    end
  end

  bcd_mod_counter #(.MAX(BCD_59)) u_sec (
    .clk(clk), .reset_n(reset_n), .inc(advance_s), .load(load_acc_s),
    .load_val(load_ss), .q(s_q_s), .q_next(s_nxt_s), .carry_out(s_carry_s)
  );

  bcd_mod_counter #(.MAX(BCD_59)) u_min (
    .clk(clk), .reset_n(reset_n), .inc(s_carry_s), .load(load_acc_s),
    .load_val(load_mm), .q(m_q_s), .q_next(m_nxt_s), .carry_out(m_carry_s)
  );

  bcd_mod_counter #(.MAX(BCD_23)) u_hour (
    .clk(clk), .reset_n(reset_n), .inc(m_carry_s), .load(load_acc_s),
    .load_val(load_hh), .q(h_q_s), .q_next(h_nxt_s), .carry_out(h_carry_s)
  );

  // Time as it will read after this cycle's advance, for the alarm compare.
  assign m_new_s = s_carry_s ? m_nxt_s : m_q_s;
  assign h_new_s = m_carry_s ? h_nxt_s : h_q_s;
  assign alarm_match_s = advance_s && alarm_en && (s_nxt_s == 8'h00)
                      && (m_new_s == alarm_mm) && (h_new_s == alarm_hh);

  // Event strobes, each live for exactly the cycle after its cause.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sec_tick_r  <= 1'b0;
      day_wrap_r  <= 1'b0;
      alarm_hit_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      sec_tick_r  <= advance_s;
      day_wrap_r  <= h_carry_s;
      alarm_hit_r <= alarm_match_s;
      load_err_r  <= load && !load_ok_s;
    end
  end

  assign h12_s = h24_to_h12(h_q_s);

  // Display format is picked combinationally so mode24 acts immediately.
  always_comb begin
    hh = h_q_s;
    if (mode24) begin
      hh = h_q_s;
    end else begin
      hh = h12_s[7:0];
    end
  end

  assign pm        = h12_s[8];
  assign mm        = m_q_s;
  assign ss        = s_q_s;
  assign sec_tick  = sec_tick_r;
  assign day_wrap  = day_wrap_r;
  assign alarm_hit = alarm_hit_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_bcd_clock_24h_alarm.sv
// Scoreboard bench for bcd_clock_24h_alarm with DIV=4: strobe events are
// checked by a monitor against a queue, steady state by direct compares.
module tb_bcd_clock_24h_alarm;

  typedef struct packed {
    logic [7:0] hh, mm, ss;
    logic       pm, st, dw, ah, le;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ena = 1'b0, mode24 = 1'b0, load = 1'b0, alarm_en = 1'b0;
  logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
  logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic [7:0] hh, mm, ss;
  logic       pm, sec_tick, day_wrap, alarm_hit, load_err;

  int   total = 0;
  int   bad = 0;
  evt_t exp_q[$];
  evt_t mon_got, mon_exp;

  bcd_clock_24h_alarm #(.DIV(4), .PW(24)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .mode24(mode24), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm), .sec_tick(sec_tick),
    .day_wrap(day_wrap), .alarm_hit(alarm_hit), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && (sec_tick || day_wrap || alarm_hit || load_err)) begin
      mon_got = '{hh, mm, ss, pm, sec_tick, day_wrap, alarm_hit, load_err};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got=%h", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL event got=%h exp=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int n);
    ena = 1'b1;
    cyc(n);
    ena = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load = 1'b1;
    load_hh = h;
    load_mm = m;
    load_ss = s;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic push(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                      input logic p, input logic st, input logic dw,
                      input logic ah, input logic le);
    exp_q.push_back('{h, m, s, p, st, dw, ah, le});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    // Reset and display format
    cyc(1);
    check("rst_time", {hh, mm, ss, pm}, {8'h12, 8'h00, 8'h00, 1'b0});
    check("rst_strobes", {sec_tick, day_wrap, alarm_hit, load_err}, 4'b0000);
    mode24 = 1'b1;
    #1;
    check("mode24_hh", hh, 8'h00);
    reset_n = 1'b1;

    // Prescaler with continuous and gapped ena
    push(8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(4);
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      ena = (i % 2 == 0);
      cyc(1);
    end
    ena = 1'b0;
    check("prescale_hold", ss, 8'h01);
    push(8'h00, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ena = 1'b1;
    cyc(1);
    ena = 1'b0;
    cyc(2);

    // Noon and midnight rollover
    mode24 = 1'b0;
    do_load(8'h11, 8'h59, 8'h59);
    check("load_11", {hh, mm, ss, pm}, {8'h11, 8'h59, 8'h59, 1'b0});
    push(8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(4);
    cyc(1);
    do_load(8'h23, 8'h59, 8'h59);
    check("load_23_12h", {hh, mm, ss, pm}, {8'h11, 8'h59, 8'h59, 1'b1});
    push(8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(4);
    cyc(1);
    mode24 = 1'b1;
    #1;
    check("wrap_24h", {hh, mm, ss, pm}, {8'h00, 8'h00, 8'h00, 1'b0});

    // Rejected and accepted loads
    push(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_load(8'h24, 8'h00, 8'h00);
    cyc(1);
    push(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_load(8'h12, 8'h5A, 8'h00);
    cyc(1);
    push(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_load(8'h09, 8'h09, 8'h3A);
    cyc(1);
    check("reject_time", {hh, mm, ss}, {8'h00, 8'h00, 8'h00});
    run(2);
    do_load(8'h09, 8'h09, 8'h09);
    check("load_09", {hh, mm, ss, pm}, {8'h09, 8'h09, 8'h09, 1'b0});
    run(3);
    check("pcnt_cleared", ss, 8'h09);
    push(8'h09, 8'h09, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1);
    cyc(1);

    // Alarm
    alarm_hh = 8'h07;
    alarm_mm = 8'h30;
    alarm_en = 1'b1;
    do_load(8'h07, 8'h29, 8'h59);
    push(8'h07, 8'h30, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(4);
    cyc(1);
    alarm_en = 1'b0;
    do_load(8'h07, 8'h29, 8'h59);
    push(8'h07, 8'h30, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(4);
    cyc(1);
    alarm_en = 1'b1;
    do_load(8'h07, 8'h30, 8'h00);
    cyc(2);
    check("load_alarm_time", {hh, mm, ss}, {8'h07, 8'h30, 8'h00});

    // Load beats a pending advance; 12h conversion of afternoon hours
    run(3);
    ena = 1'b1;
    do_load(8'h15, 8'h45, 8'h30);
    ena = 1'b0;
    check("load_wins", {hh, mm, ss, pm}, {8'h15, 8'h45, 8'h30, 1'b1});
    check("load_wins_tick", sec_tick, 1'b0);
    mode24 = 1'b0;
    #1;
    check("h12_15", hh, 8'h03);
    do_load(8'h20, 8'h00, 8'h00);
    check("h12_20", {hh, pm}, {8'h08, 1'b1});
    mode24 = 1'b1;
    #1;
    check("h24_20", hh, 8'h20);

    // Reset mid-prescale overrides load and ena
    run(2);
    reset_n = 1'b0;
    ena = 1'b1;
    do_load(8'h09, 8'h09, 8'h09);
    reset_n = 1'b1;
    ena = 1'b0;
    check("reset_mid", {hh, mm, ss, pm}, {8'h00, 8'h00, 8'h00, 1'b0});
    run(3);
    check("reset_pcnt", ss, 8'h00);
    push(8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1);
    cyc(2);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_clock_24h_alarm.md
Name: bcd_clock_24h_alarm

Overview:
Parametrised successor of the team's 12-hour BCD digital clock. It keeps time internally in 24-hour BCD and presents either 12-hour or 24-hour display format, selected at runtime. An internal prescaler turns `ena` cycles into seconds. It adds synchronous time load with BCD validation, a daily hh:mm alarm, and single-cycle event strobes for downstream display and sequencing logic.

Parameters:
- DIV, default 1: number of `ena`-qualified clk cycles per second. Legal range 1..2^24. At DIV=1, every `ena` cycle is one second, which matches the legacy clock.
- PW, default 24: prescaler counter width. Must satisfy 2^PW >= DIV.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- ena, in, 1: count enable; the prescaler advances only when ena=1.
- mode24, in, 1: display format select; 1 = 24-hour, 0 = 12-hour.
- load, in, 1: one-cycle request to load time.
- load_hh, in, 8: BCD hours to load, 24-hour format, 00..23.
- load_mm, in, 8: BCD minutes to load, 00..59.
- load_ss, in, 8: BCD seconds to load, 00..59.
- alarm_en, in, 1: alarm enable.
- alarm_hh, in, 8: BCD alarm hours, 24-hour format.
- alarm_mm, in, 8: BCD alarm minutes.
- hh, out, 8: BCD display hours (12h: 01..12; 24h: 00..23).
- mm, out, 8: BCD minutes.
- ss, out, 8: BCD seconds.
- pm, out, 1: 1 when internal hour >= 12; valid in both modes.
- sec_tick, out, 1: one-cycle pulse when a second advance takes effect.
- day_wrap, out, 1: one-cycle pulse on the 23:59:59 -> 00:00:00 advance.
- alarm_hit, out, 1: one-cycle alarm pulse.
- load_err, out, 1: one-cycle pulse when a load is rejected.

Behaviour:
- Registered state: h24, m, s (each 8-bit BCD), prescaler count pcnt, and the sec_tick, day_wrap, alarm_hit and load_err flags.
- Reset (reset_n=0 at a clk edge): h24=00, m=00, s=00, pcnt=0, all strobes 0. Display reads 12:00:00 with pm=0 in 12h mode, or 00:00:00 in 24h mode. Reset overrides load and ena.
- Priority, highest first: reset, then load, then advance.
- Prescaler: when ena=1 and load=0:
  - if pcnt == DIV-1, then pcnt <= 0 and the second advances;
  - otherwise pcnt increments.
  - When ena=0, pcnt holds its value.
- Advance:
  - s increments in BCD (09->10, 59->00).
  - A carry from s increments m (59->00).
  - A carry from m increments h24 (09->10, 23->00).
  - New values are visible the cycle after the advancing edge. sec_tick=1 in that same cycle only.
- day_wrap=1 together with sec_tick when the advance produces 00:00:00 from 23:59:59.
- alarm_hit=1 together with sec_tick when:
  - alarm_en=1, and
  - the new time equals alarm_hh:alarm_mm:00.
  - It fires once per day. It never fires from a load.
- Load:
  - Accepted only if every nibble is a decimal digit and the values are in range (hh <= 23, mm <= 59, ss <= 59).
  - When accepted: the state is written, pcnt <= 0, and no strobes fire.
  - When rejected: time and pcnt are unchanged, and load_err=1 for one cycle.
  - If load and an advance would occur in the same cycle, the load wins and the advance is discarded.
- Display conversion is combinational from h24 and mode24, so a change of mode24 is visible in the same cycle:
  - 12h mode: h24=00 -> hh=12; 01..11 -> unchanged; 12 -> 12; 13..23 -> h24-12 in BCD.
  - 24h mode: hh=h24.
  - pm = (h24 >= 0x12) in both modes.
- Unless set by the rules above, all strobes are 0. No output is X after the first reset.

Decomposition:
- Package bcd_clock_pkg holds:
  - BCD constants: BCD_59=8'h59, BCD_23=8'h23, BCD_12=8'h12.
  - Function bcd_valid(v, max).
  - Function h24_to_h12(h24) -> {pm, hh}.
- One sub-module, bcd_mod_counter: parametrised BCD counter, wrapping at MAX, with inc, load, load value and carry_out. It is instantiated three times (s, m, h24) and chained via carry.

Test Plan:
1. reset_n=0 for 1 cycle with mode24=0 -> 12:00:00, pm=0, all strobes 0. Then set mode24=1 -> hh=00 in the same cycle.
2. DIV=4, ena held high 4 cycles -> ss=01 with one sec_tick. Repeat with ena low every other cycle -> advance after 8 cycles.
3. Load 11:59:59, then one advance -> 12:00:00, pm=1 (12h mode). Load 23:59:59, then advance -> 12:00:00, pm=0, day_wrap=1 (24h mode: 00:00:00).
4. Load hh=0x24 -> load_err pulse, time unchanged. Load mm=0x5A -> rejected. Load 09:09:09 -> accepted, pcnt=0.
5. Alarm 07:30 with alarm_en=1: load 07:29:59, then advance -> alarm_hit with sec_tick. Same with alarm_en=0 -> no pulse. Load 07:30:00 directly -> no pulse.
6. load in the same cycle as a pending advance -> loaded value shown, no sec_tick. reset_n=0 mid-prescale with pcnt=2 -> pcnt=0 and time 00:00:00.
